// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I controller: FSM states, ALU and
// immediate select codes, opcode constants and datapath mux select values.
package riscv_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH,
        JAL,
        JALR,
        JALRWB,
        LUI,
        AUIPC
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } aluop_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immsrc_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller (master) and its datapath and
// memory port (slave).
interface multicycle_controller_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;

    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       illegal_op;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal_op
    );

endinterface

// File: rtl/mc_alu_decoder.sv
// ALU operation select for register/immediate arithmetic and for branch
// compares, plus the branch-taken decision derived from the ALU Zero flag.
module mc_alu_decoder
    import riscv_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       branchMode,
    output aluop_t     aluControl,
    output logic       branchTake,
    output logic       branchIllegal
);

    // blt/bltu leave a nonzero SLT result when taken, so they branch on !Zero
    always_comb begin
        aluControl    = ALU_ADD;
        branchTake    = 1'b0;
        branchIllegal = 1'b0;
        if (branchMode) begin
            case (funct3)
                3'b000: begin aluControl = ALU_SUB;  branchTake = zero;  end
                3'b001: begin aluControl = ALU_SUB;  branchTake = !zero; end
                3'b100: begin aluControl = ALU_SLT;  branchTake = !zero; end
                3'b101: begin aluControl = ALU_SLT;  branchTake = zero;  end
                3'b110: begin aluControl = ALU_SLTU; branchTake = !zero; end
                3'b111: begin aluControl = ALU_SLTU; branchTake = zero;  end
                default: branchIllegal = 1'b1;
            endcase
        end else begin
            case (funct3)
                3'b000:  aluControl = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                3'b001:  aluControl = ALU_SLL;
                3'b010:  aluControl = ALU_SLT;
                3'b011:  aluControl = ALU_SLTU;
                3'b100:  aluControl = ALU_XOR;
                3'b101:  aluControl = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  aluControl = ALU_OR;
                default: aluControl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: a Moore FSM that sequences fetch, decode,
// memory, ALU, branch and jump steps over a single shared memory port.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    multicycle_controller_if.master bus
);

    state_t state;
    state_t nextState;
    aluop_t decAlu;
    logic   decTake;
    logic   decBad;

    mc_alu_decoder aluDecoder (
        .op5           (bus.op[5]),
        .funct3        (bus.funct3),
        .funct7b5      (bus.funct7b5),
        .zero          (bus.Zero),
        .branchMode    (state == BRANCH),
        .aluControl    (decAlu),
        .branchTake    (decTake),
        .branchIllegal (decBad)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState      = state;
        bus.mem_req    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = SRCA_PC;
        bus.ALUSrcB    = SRCB_RS2;
        bus.ImmSrc     = IMM_I;
        bus.ALUControl = ALU_ADD;
        bus.illegal_op = 1'b0;

        case (state)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.PCWrite = 1'b1;
                    nextState   = DECODE;
                end
            end
            DECODE: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = IMM_B;
                case (bus.op)
                    OP_LOAD, OP_STORE: nextState = MEMADR;
                    OP_RTYPE:          nextState = EXECR;
                    OP_ITYPE:          nextState = EXECI;
                    OP_BRANCH:         nextState = BRANCH;
                    OP_JAL:            nextState = JAL;
                    OP_JALR:           nextState = JALR;
                    OP_LUI:            nextState = LUI;
                    OP_AUIPC:          nextState = AUIPC;
                    default: begin
                        bus.illegal_op = 1'b1;
                        nextState      = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = SRCA_RS1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ImmSrc  = bus.op[5] ? IMM_S : IMM_I;
                nextState   = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.AdrSrc  = 1'b1;
                if (bus.mem_ready) begin
                    nextState = MEMWB;
                end
            end
            MEMWB: begin
                bus.ResultSrc = RES_RDATA;
                bus.RegWrite  = 1'b1;
                nextState     = FETCH;
            end
            MEMWRITE: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = 1'b1;
                bus.AdrSrc   = 1'b1;
                if (bus.mem_ready) begin
                    nextState = FETCH;
                end
            end
            EXECR: begin
                bus.ALUSrcA    = SRCA_RS1;
                bus.ALUSrcB    = SRCB_RS2;
                bus.ALUControl = decAlu;
                nextState      = ALUWB;
            end
            EXECI: begin
                bus.ALUSrcA    = SRCA_RS1;
                bus.ALUSrcB    = SRCB_IMM;
                bus.ImmSrc     = IMM_I;
                bus.ALUControl = decAlu;
                nextState      = ALUWB;
            end
            ALUWB: begin
                bus.RegWrite = 1'b1;
                nextState    = FETCH;
                // After jal the link value oldPC+4 is recomputed live on the ALU.
                if (bus.op == OP_JAL) begin
                    bus.ResultSrc = RES_ALU;
                    bus.ALUSrcA   = SRCA_OLDPC;
                    bus.ALUSrcB   = SRCB_FOUR;
                end
            end
            BRANCH: begin
                bus.ALUSrcA    = SRCA_RS1;
                bus.ALUSrcB    = SRCB_RS2;
                bus.ALUControl = decAlu;
                bus.PCWrite    = decTake;
                bus.illegal_op = decBad;
                nextState      = FETCH;
            end
            JAL: begin
                bus.ALUSrcA = SRCA_OLDPC;
                bus.ALUSrcB = SRCB_FOUR;
                bus.PCWrite = 1'b1;
                nextState   = ALUWB;
            end
            JALR: begin
                bus.ALUSrcA   = SRCA_RS1;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ImmSrc    = IMM_I;
                bus.ResultSrc = RES_ALU;
                bus.PCWrite   = 1'b1;
                nextState     = JALRWB;
            end
            JALRWB: begin
                bus.ALUSrcA   = SRCA_OLDPC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                bus.RegWrite  = 1'b1;
                nextState     = FETCH;
            end
            LUI, AUIPC: begin
                bus.ALUSrcA   = (state == LUI) ? SRCA_ZERO : SRCA_OLDPC;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ImmSrc    = IMM_U;
                bus.ResultSrc = RES_ALU;
                bus.RegWrite  = 1'b1;
                nextState     = FETCH;
            end
            default: nextState = FETCH;
        endcase

        // Reset is synchronous, so the old state may still be live this cycle.
        if (!reset_n) begin
            bus.mem_req    = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.PCWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: instruction-level reference
// model producing per-cycle expected control words, table vectors and random runs.
module tb_multicycle_controller;

    typedef struct packed {
        logic       memReq;
        logic       memWrite;
        logic       adrSrc;
        logic       irWrite;
        logic       pcWrite;
        logic       regWrite;
        logic [1:0] resultSrc;
        logic [1:0] srcA;
        logic [1:0] srcB;
        logic [2:0] immSrc;
        logic [3:0] alu;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       zero;
    } instr_t;

    typedef struct {
        logic ready;
        ctl_t exp;
    } step_t;

    typedef struct {
        instr_t     ins;
        int         memWait;
        logic [3:0] expAlu;
        logic       expPc;
        logic       expReg;
        int         expMemCycles;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    multicycle_controller_if mb();

    multicycle_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mb)
    );

    always #5 clk = ~clk;

    int     compared = 0;
    int     mismatched = 0;
    step_t  steps[$];
    ctl_t   obsKey;
    logic   obsReg;
    int     obsMem;
    vec_t   vecs[18];

    function automatic ctl_t actual();
        ctl_t c;
        c.memReq    = mb.mem_req;
        c.memWrite  = mb.MemWrite;
        c.adrSrc    = mb.AdrSrc;
        c.irWrite   = mb.IRWrite;
        c.pcWrite   = mb.PCWrite;
        c.regWrite  = mb.RegWrite;
        c.resultSrc = mb.ResultSrc;
        c.srcA      = mb.ALUSrcA;
        c.srcB      = mb.ALUSrcB;
        c.immSrc    = mb.ImmSrc;
        c.alu       = mb.ALUControl;
        c.illegal   = mb.illegal_op;
        return c;
    endfunction

    function automatic logic rnd();
        return ($urandom & 32'd1) != 32'd0;
    endfunction

    function automatic logic legalOp(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    endfunction

    function automatic logic [3:0] refAlu(input instr_t ins);
        logic [3:0] byF3 [8];
        byF3 = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
        if (ins.op == 7'b1100011) begin
            if (ins.f3 < 3'd2) return 4'h1;
            if (ins.f3 < 3'd4) return 4'h0;
            if (ins.f3 < 3'd6) return 4'h5;
            return 4'h6;
        end
        if (ins.f3 == 3'd0 && ins.f7 && ins.op == 7'b0110011) return 4'h1;
        if (ins.f3 == 3'd5 && ins.f7) return 4'h9;
        return byF3[ins.f3];
    endfunction

    function automatic logic refBranch(input instr_t ins);
        logic onNotEqual;
        onNotEqual = (ins.f3 == 3'd1) || (ins.f3 == 3'd4) || (ins.f3 == 3'd6);
        return onNotEqual ? !ins.zero : ins.zero;
    endfunction

    function automatic ctl_t fetchCtl(input logic ready);
        ctl_t c;
        c = '0;
        c.memReq    = 1'b1;
        c.srcB      = 2'b10;
        c.resultSrc = 2'b10;
        c.irWrite   = ready;
        c.pcWrite   = ready;
        return c;
    endfunction

    task automatic push(input logic ready, input ctl_t c);
        step_t s;
        s.ready = ready;
        s.exp   = c;
        steps.push_back(s);
    endtask

    // Reference: the cycle-by-cycle control words one instruction should produce.
    task automatic buildSteps(input instr_t ins, input int fetchWait, input int memWait);
        ctl_t c;
        logic legalBr;
        steps.delete();
        for (int i = 0; i < fetchWait; i++) push(1'b0, fetchCtl(1'b0));
        push(1'b1, fetchCtl(1'b1));
        c = '0; c.srcA = 2'b01; c.srcB = 2'b01; c.immSrc = 3'b010;
        c.illegal = !legalOp(ins.op);
        push(rnd(), c);
        case (ins.op)
            7'b0000011, 7'b0100011: begin
                c = '0; c.srcA = 2'b10; c.srcB = 2'b01;
                c.immSrc = ins.op[5] ? 3'b001 : 3'b000;
                push(rnd(), c);
                c = '0; c.memReq = 1'b1; c.adrSrc = 1'b1; c.memWrite = ins.op[5];
                for (int i = 0; i < memWait; i++) push(1'b0, c);
                push(1'b1, c);
                if (!ins.op[5]) begin
                    c = '0; c.resultSrc = 2'b01; c.regWrite = 1'b1;
                    push(rnd(), c);
                end
            end
            7'b0110011, 7'b0010011: begin
                c = '0; c.srcA = 2'b10; c.srcB = ins.op[5] ? 2'b00 : 2'b01;
                c.alu = refAlu(ins);
                push(rnd(), c);
                c = '0; c.regWrite = 1'b1;
                push(rnd(), c);
            end
            7'b1100011: begin
                legalBr = !(ins.f3 == 3'd2 || ins.f3 == 3'd3);
                c = '0; c.srcA = 2'b10; c.alu = refAlu(ins);
                c.pcWrite = legalBr && refBranch(ins);
                c.illegal = !legalBr;
                push(rnd(), c);
            end
            7'b1101111: begin
                c = '0; c.srcA = 2'b01; c.srcB = 2'b10; c.pcWrite = 1'b1;
                push(rnd(), c);
                c = '0; c.srcA = 2'b01; c.srcB = 2'b10; c.resultSrc = 2'b10; c.regWrite = 1'b1;
                push(rnd(), c);
            end
            7'b1100111: begin
                c = '0; c.srcA = 2'b10; c.srcB = 2'b01; c.resultSrc = 2'b10; c.pcWrite = 1'b1;
                push(rnd(), c);
                c = '0; c.srcA = 2'b01; c.srcB = 2'b10; c.resultSrc = 2'b10; c.regWrite = 1'b1;
                push(rnd(), c);
            end
            7'b0110111, 7'b0010111: begin
                c = '0; c.srcA = ins.op[3] ? 2'b01 : 2'b11; c.srcB = 2'b01;
                c.immSrc = 3'b100; c.resultSrc = 2'b10; c.regWrite = 1'b1;
                if (ins.op == 7'b0110111) c.srcA = 2'b11;
                else c.srcA = 2'b01;
                push(rnd(), c);
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input logic ready, input logic rstn,
                                 input logic loadIns, input instr_t ins);
        @(negedge clk);
        mb.mem_ready = ready;
        reset_n      = rstn;
        if (loadIns) begin
            mb.op       = ins.op;
            mb.funct3   = ins.f3;
            mb.funct7b5 = ins.f7;
            mb.Zero     = ins.zero;
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input ctl_t exp);
        ctl_t act;
        act = actual();
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkStrobes(input string name);
        logic [5:0] s;
        s = {mb.mem_req, mb.MemWrite, mb.IRWrite, mb.PCWrite, mb.RegWrite, mb.illegal_op};
        compared++;
        if (s !== 6'b0) begin
            mismatched++;
            $display("[TB] FAIL %s: strobes %b expected 000000", name, s);
        end
    endtask

    task automatic runInstr(input string name, input instr_t ins,
                            input int fetchWait, input int memWait);
        buildSteps(ins, fetchWait, memWait);
        obsKey = '0;
        obsReg = 1'b0;
        obsMem = 0;
        for (int k = 0; k < steps.size(); k++) begin
            applyStimulus(steps[k].ready, 1'b1, k == 0, ins);
            checkOutput($sformatf("%s step %0d", name, k), steps[k].exp);
            if (k == fetchWait + 2) obsKey = actual();
            if (mb.RegWrite === 1'b1) obsReg = 1'b1;
            if (mb.mem_req === 1'b1 && mb.AdrSrc === 1'b1) obsMem++;
        end
    endtask

    function automatic vec_t mkVec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                   input logic zero, input int memWait, input logic [3:0] alu,
                                   input logic pc, input logic rw, input int memCyc);
        vec_t v;
        v.ins.op = op; v.ins.f3 = f3; v.ins.f7 = f7; v.ins.zero = zero;
        v.memWait = memWait; v.expAlu = alu; v.expPc = pc; v.expReg = rw;
        v.expMemCycles = memCyc;
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        instr_t ins;
        instr_t none;
        logic [6:0] opList [11];
        opList = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                   7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};
        none = '0;

        //              op          f3      f7    zero  mw  alu    pc    reg   mem
        vecs[0]  = mkVec(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b1, 0);
        vecs[1]  = mkVec(7'b0110011, 3'b000, 1'b1, 1'b1, 0, 4'h1, 1'b0, 1'b1, 0);
        vecs[2]  = mkVec(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 4'h0, 1'b0, 1'b1, 0);
        vecs[3]  = mkVec(7'b0010011, 3'b101, 1'b1, 1'b0, 0, 4'h9, 1'b0, 1'b1, 0);
        vecs[4]  = mkVec(7'b0110011, 3'b101, 1'b0, 1'b0, 0, 4'h8, 1'b0, 1'b1, 0);
        vecs[5]  = mkVec(7'b0110011, 3'b011, 1'b0, 1'b0, 0, 4'h6, 1'b0, 1'b1, 0);
        vecs[6]  = mkVec(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 4'h2, 1'b0, 1'b1, 0);
        vecs[7]  = mkVec(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 4'h1, 1'b1, 1'b0, 0);
        vecs[8]  = mkVec(7'b1100011, 3'b111, 1'b0, 1'b0, 0, 4'h6, 1'b0, 1'b0, 0);
        vecs[9]  = mkVec(7'b1100011, 3'b100, 1'b0, 1'b0, 0, 4'h5, 1'b1, 1'b0, 0);
        vecs[10] = mkVec(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 4'h1, 1'b1, 1'b0, 0);
        vecs[11] = mkVec(7'b1100011, 3'b010, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0, 0);
        vecs[12] = mkVec(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 4'h0, 1'b0, 1'b1, 4);
        vecs[13] = mkVec(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 4'h0, 1'b0, 1'b0, 2);
        vecs[14] = mkVec(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 4'h0, 1'b1, 1'b1, 0);
        vecs[15] = mkVec(7'b1100111, 3'b000, 1'b0, 1'b0, 0, 4'h0, 1'b1, 1'b1, 0);
        vecs[16] = mkVec(7'b0110111, 3'b000, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b1, 0);
        vecs[17] = mkVec(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0, 0);

        mb.mem_ready = 1'b0;
        mb.op        = '0;
        mb.funct3    = '0;
        mb.funct7b5  = 1'b0;
        mb.Zero      = 1'b0;

        $display("[TB] reset checks");
        applyStimulus(1'b1, 1'b0, 1'b0, none);
        checkStrobes("reset cycle 0");
        applyStimulus(1'b1, 1'b0, 1'b0, none);
        checkStrobes("reset cycle 1");
        applyStimulus(1'b0, 1'b1, 1'b0, none);
        checkOutput("first fetch after reset", fetchCtl(1'b0));

        $display("[TB] table vectors");
        for (int i = 0; i < 18; i++) begin
            runInstr($sformatf("vec%0d", i), vecs[i].ins, 0, vecs[i].memWait);
            checkValue($sformatf("vec%0d key alu", i), int'(obsKey.alu), int'(vecs[i].expAlu));
            checkValue($sformatf("vec%0d key pcwrite", i), int'(obsKey.pcWrite), int'(vecs[i].expPc));
            checkValue($sformatf("vec%0d regwrite seen", i), int'(obsReg), int'(vecs[i].expReg));
            checkValue($sformatf("vec%0d mem cycles", i), obsMem, vecs[i].expMemCycles);
        end

        $display("[TB] reset during store wait");
        ins = '{op: 7'b0100011, f3: 3'b010, f7: 1'b0, zero: 1'b0};
        buildSteps(ins, 0, 2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(steps[k].ready, 1'b1, k == 0, ins);
            checkOutput($sformatf("sw-reset step %0d", k), steps[k].exp);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, ins);
        checkStrobes("sw-reset asserted");
        applyStimulus(1'b0, 1'b1, 1'b0, ins);
        checkOutput("sw-reset back in fetch", fetchCtl(1'b0));

        $display("[TB] random instructions");
        for (int n = 0; n < 150; n++) begin
            ins.op   = opList[$urandom_range(0, 10)];
            ins.f3   = 3'($urandom_range(0, 7));
            ins.f7   = rnd();
            ins.zero = rnd();
            runInstr($sformatf("rand%0d", n), ins, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk and reset_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  synchronous active-low reset.
REQ-004 op  input  7  opcode of the held instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 Zero  input  1  ALU result == 0.
REQ-008 mem_ready  input  1  memory completes the current request this cycle.
REQ-009 mem_req  output  1  memory access request, held until mem_ready.
REQ-010 MemWrite  output  1  the request is a store.
REQ-011 AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address.
REQ-012 IRWrite  output  1  load the instruction register and old-PC register.
REQ-013 PCWrite  output  1  load PC from the result bus.
REQ-014 RegWrite  output  1  write rd from the result bus.
REQ-015 ResultSrc  output  2  00 ALUOut, 01 read data, 10 ALU result.
REQ-016 ALUSrcA  output  2  00 PC, 01 oldPC, 10 rs1, 11 zero.
REQ-017 ALUSrcB  output  2  00 rs2, 01 imm, 10 constant 4.
REQ-018 ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-019 ALUControl  output  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
REQ-020 illegal_op  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-021 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, AUIPC; PCWrite and IRWrite also depend on mem_ready and Zero.
REQ-022 FETCH: mem_req=1, AdrSrc=0, A=PC, B=4, ADD, ResultSrc=10; when mem_ready=1, IRWrite=1, PCWrite=1, next state DECODE; otherwise stay in FETCH with IRWrite=0 and PCWrite=0.
REQ-023 DECODE: A=oldPC, B=imm, ImmSrc=B, ADD (branch target to ALUOut).
- Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; 0010111 -> AUIPC.
- Any other op -> FETCH with illegal_op=1 for that cycle.
REQ-024 MEMADR: A=rs1, B=imm, ADD; ImmSrc=S if op[5] else I; next state MEMWRITE if op[5] else MEMREAD.
REQ-025 MEMREAD: mem_req=1, AdrSrc=1; stay until mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, next state FETCH.
REQ-026 MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1; stay until mem_ready, then FETCH.
REQ-027 EXECR: A=rs1, B=rs2. EXECI: A=rs1, B=imm, ImmSrc=I. Both go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, next state FETCH.
REQ-028 ALU decode for EXECR/EXECI, by funct3:
- 000: SUB if funct7b5 & op[5], else ADD.
- 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
- 101: SRA if funct7b5, else SRL.
- 110 OR; 111 AND.
REQ-029 BRANCH: A=rs1, B=rs2, ResultSrc=00, next state FETCH.
- beq/bne use SUB; blt/bge use SLT; bltu/bgeu use SLTU.
- PCWrite = Zero for beq/bge/bgeu and !Zero for bne/blt/bltu.
- funct3 010/011: PCWrite=0 and illegal_op=1.
REQ-030 JAL: A=oldPC, B=4, ADD, ResultSrc=00, PCWrite=1, next state ALUWB with ResultSrc=10 (writes oldPC+4).
REQ-031 JALR: A=rs1, B=imm, ImmSrc=I, ADD, ResultSrc=10, PCWrite=1, next state JALRWB.
- JALRWB: A=oldPC, B=4, ADD, ResultSrc=10, RegWrite=1, next state FETCH.
REQ-032 LUI: A=zero, B=imm. AUIPC: A=oldPC, B=imm. Both use ImmSrc=U, ADD, ResultSrc=10, RegWrite=1, next state FETCH.
REQ-033 Every signal not listed for a state SHALL be 0 in that state.
- At most one of RegWrite, MemWrite and IRWrite SHALL be high in any cycle.
- Outputs SHALL never be X.
REQ-034 mem_ready outside FETCH, MEMREAD and MEMWRITE SHALL be ignored.

Reset
REQ-035 While reset_n=0 at a clock edge, next state SHALL be FETCH, whatever the current state (including a wait in MEMREAD/MEMWRITE).
REQ-036 While reset_n=0, mem_req, MemWrite, IRWrite, PCWrite, RegWrite and illegal_op SHALL be 0.
- The first FETCH request SHALL be issued in the cycle after reset_n is seen high.

Structure
REQ-037 The state encoding, ALUControl codes, ImmSrc codes and opcode constants SHALL live in a shared package, riscv_pkg.
REQ-038 ALU decode (REQ-028 and the branch selection in REQ-029) SHALL be one sub-module, mc_alu_decoder; the FSM stays in the top module.

Verification
REQ-039 Reset then add x3,x1,x2 with mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB,FETCH; RegWrite=1 only in ALUWB; ALUControl=0001 for sub.
REQ-040 lw with mem_ready held low 3 cycles in MEMREAD -> mem_req=1 and AdrSrc=1 held for 4 cycles; MEMWB follows with ResultSrc=01.
REQ-041 bne with Zero=0 -> PCWrite=1 in BRANCH; bgeu with Zero=0 -> PCWrite=0; ALUControl=0110.
REQ-042 jalr -> PCWrite=1 with ResultSrc=10 in JALR, then RegWrite=1 in JALRWB with A=01, B=10.
REQ-043 op=1111111 -> illegal_op pulses one cycle in DECODE, then FETCH; no RegWrite/MemWrite/PCWrite.
REQ-044 reset_n low during a MEMWRITE wait -> next cycle is FETCH with MemWrite=0, and no write is issued.
